// File: rtl/mat_vec_solve.sv
// Computes x = inv * b for a 5x5 inverse using one MAC per cycle.
// Ports: clk/rst/start in; inv/pivot/b flat buses in; busy/x_valid/x_idx/x_out/done/singular/sat out.
module mat_vec_solve #(
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [25*W-1:0] inv_flat,
  input  logic [5*W-1:0]  pivot_flat,
  input  logic [5*W-1:0]  b_flat,
  output logic            busy,
  output logic            x_valid,
  output logic [2:0]      x_idx,
  output logic [W-1:0]    x_out,
  output logic            done,
  output logic            singular,
  output logic            sat
);

  localparam int AW = 2*W + 3;
  localparam logic signed [AW-1:0] MAXV =
    {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CHECK, MAC} state_t;

  state_t state, state_nx;

  logic [25*W-1:0] inv_q;
  logic [5*W-1:0]  piv_q;
  logic [5*W-1:0]  b_q;
  logic [2:0]      r;
  logic [2:0]      c;
  logic [4:0]      k;

  logic signed [W-1:0]   a_el;
  logic signed [W-1:0]   b_el;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  acc_nx;
  logic [W-1:0]          x_cl;
  logic                  clamp_hit;
  logic                  piv_zero;
  logic                  accept;
  logic                  last;

  // A start landing in the done cycle is dropped.
  assign accept = (state == IDLE) && start && !done;
  assign last   = (r == 3'd4) && (c == 3'd4);

  always_comb begin
    piv_zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (piv_q[i*W +: W] == '0) piv_zero = 1'b1;
    end
  end

  always_comb begin
    k    = 5'(r) * 5'd5 + 5'(c);
    a_el = inv_q[k*W +: W];
    b_el = b_q[c*W +: W];
    prod = a_el * b_el;
    if (c == 3'd0) acc_nx = AW'(prod);
    else           acc_nx = acc + AW'(prod);
  end

  always_comb begin
    clamp_hit = 1'b0;
    x_cl      = acc_nx[W-1:0];
    if (acc_nx > MAXV) begin
      clamp_hit = 1'b1;
      x_cl      = MAXV[W-1:0];
    end else if (acc_nx < MINV) begin
      clamp_hit = 1'b1;
      x_cl      = MINV[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = CHECK;
      CHECK:   state_nx = piv_zero ? IDLE : MAC;
      MAC:     if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q    <= '0;
      piv_q    <= '0;
      b_q      <= '0;
      r        <= '0;
      c        <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      x_valid  <= 1'b0;
      x_idx    <= '0;
      x_out    <= '0;
      done     <= 1'b0;
      singular <= 1'b0;
      sat      <= 1'b0;
    end else begin
      x_valid <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            inv_q    <= inv_flat;
            piv_q    <= pivot_flat;
            b_q      <= b_flat;
            singular <= 1'b0;
            sat      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CHECK: begin
          r <= '0;
          c <= '0;
          if (piv_zero) begin
            singular <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
          end
        end
        MAC: begin
          acc <= acc_nx;
          if (c == 3'd4) begin
            x_out   <= x_cl;
            x_idx   <= r;
            x_valid <= 1'b1;
            if (clamp_hit) sat <= 1'b1;
            c <= '0;
            r <= r + 3'd1;
            if (r == 3'd4) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end else begin
            c <= c + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
